age_bank_arbiter: RTL

Round-robin conflict arbiter between one AGE group and its SpM bank group; sits directly upstream of the AGE-to-bank crossbar. Each cycle it grants at most one AGE per bank and returns a per-AGE grant, so losing AGEs hold their request. It forwards only granted requests, registered and still AGE-indexed, so the crossbar never sees two enabled AGEs on one bank. It also keeps fair per-bank priority and a conflict-cycle counter for profiling.

---
 rtl/mage_pkg.sv | 29 ++
 rtl/age_bank_arbiter_rr_arbiter.sv | 31 +++
 rtl/age_bank_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mage_pkg.sv
// Shared constants and types for the AGE / SpM bank boundary of one stream.
package mage_pkg;

   localparam int N_AGE_PER_STREAM   = 4;
   localparam int N_BANKS_PER_STREAM = 4;
   localparam int NBIT_ADDR          = 16;

   // Width of a pointer that selects one AGE of the group.
   localparam int AGE_PTR_W = (N_AGE_PER_STREAM > 1) ? $clog2(N_AGE_PER_STREAM) : 1;

   // One AGE request as it crosses the arbiter / crossbar boundary.
   typedef struct packed {
      logic                          valid;
      logic [N_BANKS_PER_STREAM-1:0] bank;
      logic                          we;
      logic [NBIT_ADDR-1:0]          addr;
   } age_req_t;

   // True when exactly one bank select bit is set.
   function automatic logic is_onehot(input logic [N_BANKS_PER_STREAM-1:0] v);
      int unsigned n;
      n = 0;
      for (int b = 0; b < N_BANKS_PER_STREAM; b++) begin
         if (v[b]) n++;
      end
      return (n == 1);
   endfunction

endpackage

// File: rtl/age_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at ptr_i, ptr_i+1, ... mod N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] gnt_idx_o
);

   int   idx;
   logic found;

   // Scan from the pointer position, wrapping, and grant the first requester.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr_i) + off) % N;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/age_bank_arbiter.sv
// Per-bank round-robin conflict arbiter in front of the AGE-to-bank crossbar.
// Grants at most one AGE per bank each cycle and forwards only granted
// requests, registered and still indexed by AGE.
//
// Handshake: an AGE request is consumed in the cycle where
// age_valid_i[i] & age_gnt_o[i] is high; until then the AGE holds valid,
// bank, we and addr stable. age_gnt_o never depends on any output.
module age_bank_arbiter
   import mage_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                                                clk_i,
   input  logic                                                rst_i,
   input  logic                                                clear_i,
   input  logic [N_AGE_PER_STREAM-1:0]                         age_valid_i,
   input  logic [N_AGE_PER_STREAM-1:0][N_BANKS_PER_STREAM-1:0] age_bank_i,
   input  logic [N_AGE_PER_STREAM-1:0]                         age_we_i,
   input  logic [N_AGE_PER_STREAM-1:0][NBIT_ADDR-1:0]          age_addr_i,
   output logic [N_AGE_PER_STREAM-1:0]                         age_gnt_o,
   output logic [N_AGE_PER_STREAM-1:0]                         age_valid_o,
   output logic [N_AGE_PER_STREAM-1:0][N_BANKS_PER_STREAM-1:0] age_bank_o,
   output logic [N_AGE_PER_STREAM-1:0]                         age_we_o,
   output logic [N_AGE_PER_STREAM-1:0][NBIT_ADDR-1:0]          age_addr_o,
   output logic                                                stall_o,
   output logic [CNT_W-1:0]                                    conflict_cnt_o,
   output logic                                                bank_err_o,
   output logic [N_BANKS_PER_STREAM-1:0][AGE_PTR_W-1:0]        rr_q_dbg_o
);

   localparam int N_AGE   = N_AGE_PER_STREAM;
   localparam int N_BANKS = N_BANKS_PER_STREAM;

   logic [N_AGE-1:0]                    wf_req;
   logic [N_AGE-1:0]                    bad_req;
   logic [N_BANKS-1:0][N_AGE-1:0]       bank_col;
   logic [N_BANKS-1:0][N_AGE-1:0]       bank_gnt;
   logic [N_BANKS-1:0][AGE_PTR_W-1:0]   bank_idx;
   logic [N_BANKS-1:0][AGE_PTR_W-1:0]   rr_q;
   logic [N_BANKS-1:0][AGE_PTR_W-1:0]   rr_d;
   logic [N_AGE-1:0]                    age_gnt;
   logic                                stall;
   age_req_t [N_AGE-1:0]                out_d;
   age_req_t [N_AGE-1:0]                out_q;
   logic [CNT_W-1:0]                    cnt_q;
   logic                                err_q;

   // Classify requests and transpose well-formed ones into per-bank columns.
   always_comb begin
      wf_req   = '0;
      bad_req  = '0;
      bank_col = '0;
      for (int i = 0; i < N_AGE; i++) begin
         wf_req[i]  = age_valid_i[i] & is_onehot(age_bank_i[i]);
         bad_req[i] = age_valid_i[i] & ~is_onehot(age_bank_i[i]);
         for (int b = 0; b < N_BANKS; b++) begin
            bank_col[b][i] = wf_req[i] & age_bank_i[i][b];
         end
      end
   end

   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      rr_arbiter #(
         .N     (N_AGE),
         .PTR_W (AGE_PTR_W)
      ) u_rr_arbiter (
         .req_i     (bank_col[b]),
         .ptr_i     (rr_q[b]),
         .gnt_o     (bank_gnt[b]),
         .gnt_idx_o (bank_idx[b])
      );
   end

   // Merge per-bank grants, derive stall, next pointers and forwarded fields.
   always_comb begin
      age_gnt = '0;
      rr_d    = rr_q;
      out_d   = '0;
      for (int b = 0; b < N_BANKS; b++) begin
         age_gnt = age_gnt | bank_gnt[b];
         if (|bank_gnt[b]) begin
            rr_d[b] = (bank_idx[b] == AGE_PTR_W'(N_AGE - 1)) ? '0 : bank_idx[b] + 1'b1;
         end
      end
      stall = |(wf_req & ~age_gnt);
      for (int i = 0; i < N_AGE; i++) begin
         if (age_gnt[i]) begin
            out_d[i].valid = 1'b1;
            out_d[i].bank  = age_bank_i[i];
            out_d[i].we    = age_we_i[i];
            out_d[i].addr  = age_addr_i[i];
         end
      end
   end

   // State update; reset and clear drop everything, including this cycle's grants.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         rr_q  <= '0;
         out_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         out_q <= out_d;
         if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
         if (|bad_req) err_q <= 1'b1;
      end
   end

   // Unpack the registered requests onto the crossbar-facing ports.
   always_comb begin
      for (int i = 0; i < N_AGE; i++) begin
         age_valid_o[i] = out_q[i].valid;
         age_bank_o[i]  = out_q[i].bank;
         age_we_o[i]    = out_q[i].we;
         age_addr_o[i]  = out_q[i].addr;
      end
   end

   assign age_gnt_o      = age_gnt;
   assign stall_o        = stall;
   assign conflict_cnt_o = cnt_q;
   assign bank_err_o     = err_q;
   assign rr_q_dbg_o     = rr_q;

endmodule
